// File: rtl/gray_monitor.sv
// gray_monitor
//   Tracks a 3-bit Gray-code counter stream. Each sampled code is converted
//   to binary and must either repeat the previous value or advance by one
//   (mod 8). Forward 7->0 steps are counted as wraps, and the wrap count
//   saturates at all-ones. A rising Overflow is legal only on a wrap.
//   Any inconsistency latches a fault until Resync or Reset.
//
// Ports
//   Clk       clock, rising edge
//   Reset     asynchronous active-high reset
//   En        sample strobe for Gray/Overflow
//   Resync    synchronous return to INIT (priority over En)
//   Gray      3-bit Gray code from the upstream counter
//   Overflow  upstream overflow flag
//   Bin       binary value of the last accepted code
//   Wraps     saturating wrap count
//   Count     {Wraps, Bin}
//   Valid     high while tracking
//   Error     high while faulted
//   ErrCode   fault cause: bit0 illegal step, bit1 overflow mismatch
module gray_monitor #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic              Resync,
  input  logic [2:0]        Gray,
  input  logic              Overflow,
  output logic [2:0]        Bin,
  output logic [WRAP_W-1:0] Wraps,
  output logic [WRAP_W+2:0] Count,
  output logic              Valid,
  output logic              Error,
  output logic [1:0]        ErrCode
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [2:0]        bin_q, bin_n;
  logic [WRAP_W-1:0] wraps_q, wraps_n;
  logic              ovfprev_q, ovfprev_n;
  logic [1:0]        errcode_q, errcode_n;
  logic              valid_q, valid_n;
  logic              error_q, error_n;

  logic [2:0] sample;
  logic       is_hold, is_step, is_wrap, illegal, mismatch;

  always_comb begin
    sample[2] = Gray[2];
    sample[1] = Gray[2] ^ Gray[1];
    sample[0] = sample[1] ^ Gray[0];
  end

  always_comb begin
    is_hold  = (sample == bin_q);
    is_step  = (sample == bin_q + 3'd1);
    is_wrap  = is_step && (bin_q == 3'd7);
    illegal  = !is_hold && !is_step;
    mismatch = Overflow && !ovfprev_q && !is_wrap;
  end

  always_comb begin
    state_n   = state_q;
    bin_n     = bin_q;
    wraps_n   = wraps_q;
    ovfprev_n = ovfprev_q;
    errcode_n = errcode_q;

    case (state_q)
      INIT: begin
        if (En) begin
          bin_n     = sample;
          ovfprev_n = Overflow;
          state_n   = TRACK;
        end
      end
      TRACK: begin
        if (En) begin
          if (illegal || mismatch) begin
            state_n   = FAULT;
            errcode_n = {mismatch, illegal};
          end else begin
            bin_n     = sample;
            ovfprev_n = Overflow;
            if (is_wrap && (wraps_q != '1))
              wraps_n = wraps_q + WRAP_W'(1);
          end
        end
      end
      FAULT: begin
      end
      default: state_n = INIT;
    endcase

    // Resync overrides whatever the En sample would have done on this edge.
    if (Resync) begin
      state_n   = INIT;
      errcode_n = '0;
      bin_n     = bin_q;
      wraps_n   = wraps_q;
      ovfprev_n = ovfprev_q;
    end

    valid_n = (state_n == TRACK);
    error_n = (state_n == FAULT);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= INIT;
      bin_q     <= '0;
      wraps_q   <= '0;
      ovfprev_q <= 1'b0;
      errcode_q <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      bin_q     <= bin_n;
      wraps_q   <= wraps_n;
      ovfprev_q <= ovfprev_n;
      errcode_q <= errcode_n;
      valid_q   <= valid_n;
      error_q   <= error_n;
    end
  end

  assign Bin     = bin_q;
  assign Wraps   = wraps_q;
  assign Count   = {wraps_q, bin_q};
  assign Valid   = valid_q;
  assign Error   = error_q;
  assign ErrCode = errcode_q;

endmodule

// File: tb/tb_gray_monitor.sv
module tb_gray_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default WRAP_W
  logic        rst, en, resync, ovf;
  logic [2:0]  gray;
  logic [2:0]  bin;
  logic [7:0]  wraps;
  logic [10:0] count;
  logic        valid, error;
  logic [1:0]  errcode;

  // Instance B: WRAP_W = 2 for saturation
  logic        rst2, en2, ovf2;
  logic [2:0]  gray2;
  logic [2:0]  bin2;
  logic [1:0]  wraps2;
  logic [4:0]  count2;
  logic        valid2, error2;
  logic [1:0]  errcode2;

  int errors = 0;
  int checks = 0;

  // Gray codes for binary 0..7
  logic [2:0] gtab [8];

  gray_monitor #(.WRAP_W(8)) dut_a (
    .Clk(clk), .Reset(rst), .En(en), .Resync(resync), .Gray(gray),
    .Overflow(ovf), .Bin(bin), .Wraps(wraps), .Count(count),
    .Valid(valid), .Error(error), .ErrCode(errcode)
  );

  gray_monitor #(.WRAP_W(2)) dut_b (
    .Clk(clk), .Reset(rst2), .En(en2), .Resync(1'b0), .Gray(gray2),
    .Overflow(ovf2), .Bin(bin2), .Wraps(wraps2), .Count(count2),
    .Valid(valid2), .Error(error2), .ErrCode(errcode2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stepa(input logic e, input logic [2:0] g, input logic o, input logic rs);
    @(negedge clk);
    en = e; gray = g; ovf = o; resync = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic stepb(input logic e, input logic [2:0] g);
    @(negedge clk);
    en2 = e; gray2 = g; ovf2 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
    gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;

    rst = 1'b1; en = 1'b0; resync = 1'b0; ovf = 1'b0; gray = 3'b000;
    rst2 = 1'b1; en2 = 1'b0; ovf2 = 1'b0; gray2 = 3'b000;
    #3;
    check("rst_bin", 32'(bin), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_errcode", 32'(errcode), 32'd0);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;

    // 1: full lap, Overflow rises on the wrap
    for (int i = 0; i < 9; i++) begin
      stepa(1'b1, gtab[i % 8], (i == 8), 1'b0);
      check($sformatf("t1_bin%0d", i), 32'(bin), 32'(i % 8));
      check($sformatf("t1_valid%0d", i), 32'(valid), 32'd1);
    end
    check("t1_wraps", 32'(wraps), 32'd1);
    check("t1_count", 32'(count), 32'd8);
    check("t1_error", 32'(error), 32'd0);

    // 2: hold sample then ignored En=0 cycles
    stepa(1'b1, 3'b001, 1'b0, 1'b0);
    stepa(1'b1, 3'b011, 1'b0, 1'b0);
    check("t2_bin_pre", 32'(bin), 32'd2);
    stepa(1'b1, 3'b011, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) stepa(1'b0, 3'b111, 1'b0, 1'b0);
    check("t2_bin", 32'(bin), 32'd2);
    check("t2_error", 32'(error), 32'd0);
    check("t2_valid", 32'(valid), 32'd1);

    // 3: illegal jump 0 -> 3
    for (int i = 3; i < 9; i++) stepa(1'b1, gtab[i % 8], 1'b0, 1'b0);
    check("t3_bin0", 32'(bin), 32'd0);
    check("t3_wraps2", 32'(wraps), 32'd2);
    stepa(1'b1, 3'b010, 1'b0, 1'b0);
    check("t3_error", 32'(error), 32'd1);
    check("t3_errcode", 32'(errcode), 32'd1);
    check("t3_valid", 32'(valid), 32'd0);
    check("t3_bin_frozen", 32'(bin), 32'd0);
    stepa(1'b1, 3'b001, 1'b0, 1'b0);
    check("t3_still_bin", 32'(bin), 32'd0);
    check("t3_still_err", 32'(error), 32'd1);
    stepa(1'b1, 3'b110, 1'b0, 1'b1);
    check("t3_rs_errcode", 32'(errcode), 32'd0);
    check("t3_rs_error", 32'(error), 32'd0);
    check("t3_rs_valid", 32'(valid), 32'd0);
    check("t3_rs_bin", 32'(bin), 32'd0);
    stepa(1'b1, 3'b110, 1'b0, 1'b0);
    check("t3_init_bin", 32'(bin), 32'd4);
    check("t3_init_valid", 32'(valid), 32'd1);
    check("t3_init_wraps", 32'(wraps), 32'd2);

    // 4: overflow mismatch, then both causes
    stepa(1'b0, 3'b000, 1'b0, 1'b1);
    stepa(1'b1, 3'b010, 1'b0, 1'b0);
    check("t4_bin3", 32'(bin), 32'd3);
    stepa(1'b1, 3'b110, 1'b1, 1'b0);
    check("t4_errcode_ovf", 32'(errcode), 32'd2);
    check("t4_bin_frozen", 32'(bin), 32'd3);
    stepa(1'b0, 3'b000, 1'b0, 1'b1);
    stepa(1'b1, 3'b010, 1'b0, 1'b0);
    stepa(1'b1, 3'b101, 1'b1, 1'b0);
    check("t4_errcode_both", 32'(errcode), 32'd3);
    check("t4_error_both", 32'(error), 32'd1);
    stepa(1'b0, 3'b000, 1'b0, 1'b1);

    // 6: reset between edges, then first sample unchecked
    stepa(1'b1, 3'b011, 1'b0, 1'b0);
    check("t6_pre_bin", 32'(bin), 32'd2);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_error", 32'(error), 32'd0);
    check("t6_rst_errcode", 32'(errcode), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stepa(1'b1, 3'b101, 1'b0, 1'b0);
    check("t6_bin", 32'(bin), 32'd6);
    check("t6_valid", 32'(valid), 32'd1);
    check("t6_wraps", 32'(wraps), 32'd0);

    // 5: saturation on the 2-bit wrap counter
    stepb(1'b1, 3'b000);
    for (int w = 1; w <= 5; w++) begin
      for (int i = 1; i < 9; i++) stepb(1'b1, gtab[i % 8]);
      check($sformatf("t5_wraps%0d", w), 32'(wraps2), (w > 3) ? 32'd3 : 32'(w));
    end
    check("t5_count", 32'(count2), 32'd24);
    check("t5_error", 32'(error2), 32'd0);
    stepb(1'b1, 3'b001);
    check("t5_count_adv", 32'(count2), 32'd25);
    check("t5_valid", 32'(valid2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_monitor.md
# gray_monitor

Downstream consumer of the 3-bit Gray-code counter. It samples the counter's `Output` and `Overflow` and converts each code to binary. It checks that every new code is either the same as the previous one or exactly one forward step, and keeps a wrap count. The result is an extended binary position `Count = {Wraps, Bin}` for later stages, plus a sticky fault indication when the counter stream is inconsistent.

## Interface
Parameters:
- `WRAP_W`, default 8: width of the wrap counter. `Count` is `WRAP_W+3` bits wide.

Ports:
- `Clk` input, 1: clock. All state changes on the rising edge.
- `Reset` input, 1: asynchronous reset, active-high. It clears all state immediately, independent of `Clk`.
- `En` input, 1: sample strobe. `Gray` and `Overflow` are sampled on edges where `En`=1.
- `Resync` input, 1: synchronous return to INIT. It has priority over `En`.
- `Gray` input, 3: Gray code from the upstream counter's `Output`.
- `Overflow` input, 1: upstream overflow flag.
- `Bin` output, 3: binary value of the last accepted code.
- `Wraps` output, WRAP_W: number of detected 7→0 wraps. Saturates at all-ones.
- `Count` output, WRAP_W+3: `{Wraps, Bin}`.
- `Valid` output, 1: high in TRACK.
- `Error` output, 1: high in FAULT.
- `ErrCode` output, 2: fault cause. bit0 = illegal step, bit1 = overflow mismatch.

## Operation
Gray-to-binary conversion (combinational on `Gray`):
- `b2 = g2`
- `b1 = g2^g1`
- `b0 = b1^g0`

Internal registers:
- `Bin`
- `Wraps`
- `OvfPrev` (last sampled `Overflow`)
- state
- `ErrCode`

Classification of a sample `n` against the current `Bin` `p`:
- hold: `n == p`.
- step: `n == p+1` (mod 8).
- wrap: step with `p==7`, `n==0`.
- illegal: any other `n`.
- overflow mismatch: `Overflow`=1, `OvfPrev`=0, and the sample is not a wrap.

State machine:
- INIT (reset state):
  - On an `En` sample, load `Bin`←`n` and `OvfPrev`←`Overflow`. No checks are applied.
  - → TRACK.
- TRACK:
  - On an `En` sample with no illegal step and no mismatch: `Bin`←`n`, `OvfPrev`←`Overflow`. On a wrap, `Wraps`←`Wraps+1`, saturating at `2^WRAP_W-1`. Stay in TRACK.
  - On an `En` sample with an illegal step and/or a mismatch: → FAULT. `ErrCode` bits are set per cause; both causes give `11`. `Bin`, `Wraps` and `OvfPrev` are NOT updated.
- FAULT:
  - All registers are frozen and `En` is ignored.
  - The only exits are `Resync` or `Reset`.
- `Resync`=1 from any state:
  - → INIT.
  - `ErrCode`←0.
  - `Bin`, `Wraps` and `OvfPrev` keep their values.
  - `En` on the same edge is ignored.
- `En`=0 (and no `Resync`): nothing changes.

Hold samples are legal and change nothing except `OvfPrev`.

A falling `Overflow` (1→0) is never an error. It only updates `OvfPrev`.

## Timing
Reset values (asynchronous, applied while `Reset`=1):
- `Bin`=0
- `Wraps`=0
- `Count`=0
- `Valid`=0
- `Error`=0
- `ErrCode`=00
- `OvfPrev`=0
- state INIT

Output registration and latency:
- All outputs are registered.
- The result of a sample taken at edge k is visible immediately after edge k, i.e. one-cycle latency from the input being presented.
- `Valid` rises after the first `En` edge following reset or `Resync`.
- `Error` and `ErrCode` appear after the edge that samples the offending code.

Reset mid-operation:
- Asserting `Reset` between edges clears the outputs at once.
- The first edge after `Reset` deasserts behaves as INIT.

`Wraps` saturation:
- At `2^WRAP_W-1`, further wraps leave `Wraps` unchanged and raise no error.
- `Bin` still advances.

## Test plan
1. Reset, then `En`=1 with the sequence 000,001,011,010,110,111,101,100,000, with `Overflow` going 0→1 on the final 000.
   - Required: `Bin` steps 0..7 then 0, `Wraps`=1, `Count`=8, `Valid`=1, `Error`=0.
2. In TRACK at `Bin`=2, present 011, then `En`=0 for 3 cycles with `Gray` changing to 111.
   - Required: `Bin` stays 2, no error, because the 011 sample is a hold and the `En`=0 cycles are ignored.
3. In TRACK at `Bin`=0, present 010 (binary 3).
   - Required: `Error`=1, `ErrCode`=01, `Valid`=0, `Bin`=0 frozen.
   - Further `En` samples change nothing.
   - `Resync` → INIT with `ErrCode`=00. Next sample 110 gives `Bin`=4, `Valid`=1.
4. In TRACK at `Bin`=3 with `OvfPrev`=0, present 110 (binary 4) with `Overflow`=1.
   - Required: `ErrCode`=10.
   - Variant: present 101 with `Overflow`=1 → `ErrCode`=11.
5. With `WRAP_W`=2, run 5 full wraps.
   - Required: `Wraps` saturates at 3, `Count`={3,`Bin`}, no error.
6. Assert `Reset` mid-sequence between edges.
   - Required: all outputs go to 0 before the next edge.
   - After deassert, the first sample 101 is accepted without a check and gives `Bin`=6.
